// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit with a 2-entry {pc, instr} prefetch queue sharing a
// single-port memory with the load/store path. Load/store always wins the
// memory port; fetch only uses it when the port is otherwise idle.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   fetch_en                 permits instruction fetch
//   mem_ad/mem_data/mem_we   shared memory address, write data, write enable
//   mem_rd                   memory read data (combinational from mem_ad)
//   ls_req/ls_we/ls_ad/ls_wdata  load/store request from execute
//   ls_rdata                 load data (pass-through of mem_rd)
//   redir_valid/redir_pc     branch/jump redirect
//   instr_valid/instr/instr_pc   queue head presented to decode
//   instr_ready              decode accepts the head this cycle
module instr_fetch_queue #(
  parameter int unsigned W  = 17,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_en,
  output logic [AW-1:0] mem_ad,
  output logic [W-1:0]  mem_data,
  output logic          mem_we,
  input  logic [W-1:0]  mem_rd,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_ad,
  input  logic [W-1:0]  ls_wdata,
  output logic [W-1:0]  ls_rdata,
  input  logic          redir_valid,
  input  logic [AW-1:0] redir_pc,
  output logic          instr_valid,
  output logic [W-1:0]  instr,
  output logic [AW-1:0] instr_pc,
  input  logic          instr_ready
);

  localparam int unsigned CW = 2;

  logic [AW-1:0] r_pc;
  logic [CW-1:0] r_count;
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [W-1:0]  r_data [0:1];
  logic [AW-1:0] r_pcq  [0:1];

  logic w_pop;
  logic w_fetch;

  // Shared memory port: load/store has unconditional priority.
  assign mem_ad   = ls_req ? ls_ad : r_pc;
  assign mem_we   = ls_req & ls_we;
  assign mem_data = ls_wdata;
  assign ls_rdata = mem_rd;

  // Queue head straight from the storage registers.
  assign instr_valid = (r_count != CW'(0));
  assign instr       = r_data[r_rd_ptr];
  assign instr_pc    = r_pcq[r_rd_ptr];

  assign w_pop   = instr_valid & instr_ready;
  // A full queue may still accept a push when the head leaves this cycle.
  assign w_fetch = fetch_en & ~ls_req & ~redir_valid &
                   ((r_count < CW'(2)) | w_pop);

  // Control state: pc, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc     <= '0;
      r_count  <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else if (redir_valid) begin
      // Redirect flushes the queue; any pop/push this cycle is discarded.
      r_pc     <= redir_pc;
      r_count  <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_fetch) begin
        r_pc     <= r_pc + AW'(1);
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_fetch, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue payload; no reset needed since occupancy qualifies it. When full
  // with a simultaneous pop, wr_ptr equals rd_ptr so the leaving head's slot
  // is the one overwritten.
  always_ff @(posedge clk) begin
    if (rst_n && w_fetch) begin
      r_data[r_wr_ptr] <= mem_rd;
      r_pcq[r_wr_ptr]  <= r_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

  localparam int unsigned W  = 17;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_en;
  logic [AW-1:0] mem_ad;
  logic [W-1:0]  mem_data;
  logic          mem_we;
  logic [W-1:0]  mem_rd;
  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_ad;
  logic [W-1:0]  ls_wdata;
  logic [W-1:0]  ls_rdata;
  logic          redir_valid;
  logic [AW-1:0] redir_pc;
  logic          instr_valid;
  logic [W-1:0]  instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;

  logic [W-1:0] tb_mem [0:255];

  always #5 clk = ~clk;

  assign mem_rd = tb_mem[mem_ad];

  instr_fetch_queue #(.W(W), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_en   (fetch_en),
    .mem_ad     (mem_ad),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .mem_rd     (mem_rd),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .ls_ad      (ls_ad),
    .ls_wdata   (ls_wdata),
    .ls_rdata   (ls_rdata),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched {pc, instr} pairs plus a pc counter.
  typedef struct {
    logic [AW-1:0] pc;
    logic [W-1:0]  ins;
  } ent_t;

  ent_t          mq[$];
  logic [AW-1:0] m_pc;
  bit            m_ok = 1'b0;

  task automatic set(input bit rn, input bit fen, input bit rdy,
                     input bit lq, input bit lw, input logic [AW-1:0] la,
                     input logic [W-1:0] wd, input bit rv, input logic [AW-1:0] rp);
    rst_n = rn; fetch_en = fen; instr_ready = rdy;
    ls_req = lq; ls_we = lw; ls_ad = la; ls_wdata = wd;
    redir_valid = rv; redir_pc = rp;
  endtask

  // Called at negedge+1: compare against model, advance model, cross the edge.
  task automatic tick();
    logic [AW-1:0] exp_ad;
    bit            we_s;
    logic [AW-1:0] ad_s;
    logic [W-1:0]  wd_s;
    bit            pop;
    bit            fetch;
    exp_ad = ls_req ? ls_ad : m_pc;
    if (m_ok) begin
      chk("m_valid", 32'(instr_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("m_instr", 32'(instr), 32'(mq[0].ins));
        chk("m_instr_pc", 32'(instr_pc), 32'(mq[0].pc));
      end
      chk("m_mem_ad", 32'(mem_ad), 32'(exp_ad));
      chk("m_ls_rdata", 32'(ls_rdata), 32'(tb_mem[exp_ad]));
    end
    chk("m_mem_we", 32'(mem_we), 32'(ls_req && ls_we));
    chk("m_mem_data", 32'(mem_data), 32'(ls_wdata));
    we_s = ls_req && ls_we;
    ad_s = ls_ad;
    wd_s = ls_wdata;
    if (!rst_n) begin
      mq.delete();
      m_pc = '0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      if (redir_valid) begin
        mq.delete();
        m_pc = redir_pc;
      end else begin
        pop   = (mq.size() != 0) && instr_ready;
        fetch = fetch_en && !ls_req && ((mq.size() < 2) || pop);
        if (pop) void'(mq.pop_front());
        if (fetch) begin
          mq.push_back('{m_pc, tb_mem[m_pc]});
          m_pc = m_pc + AW'(1);
        end
      end
    end
    @(posedge clk);
    #1;
    if (we_s) tb_mem[ad_s] = wd_s;
    @(negedge clk);
  endtask

  typedef struct {
    bit            rn;
    bit            fen;
    bit            rdy;
    bit            do_chk;
    bit            ev;
    logic [AW-1:0] epc;
    logic [W-1:0]  ein;
  } vec_t;

  vec_t tbl [0:15];

  initial begin
    logic [AW-1:0] pcs [0:3];

    for (int i = 0; i < 256; i++) tb_mem[i] = W'(17'h10000 | i);
    tb_mem[0] = 17'h02A00;
    tb_mem[1] = 17'h0E10C;
    tb_mem[2] = 17'h0E10E;

    // rn fen rdy chk valid pc instr  (outputs seen in the cycle the inputs apply)
    tbl[0]  = '{0, 0, 0, 0, 0, 8'h00, 17'h00000};
    tbl[1]  = '{1, 1, 1, 1, 0, 8'h00, 17'h00000};
    tbl[2]  = '{1, 1, 1, 1, 1, 8'h00, 17'h02A00};
    tbl[3]  = '{1, 1, 1, 1, 1, 8'h01, 17'h0E10C};
    tbl[4]  = '{1, 1, 1, 1, 1, 8'h02, 17'h0E10E};
    tbl[5]  = '{1, 0, 1, 1, 1, 8'h03, 17'h10003};
    tbl[6]  = '{0, 0, 0, 1, 0, 8'h00, 17'h00000};
    tbl[7]  = '{1, 1, 0, 1, 0, 8'h00, 17'h00000};
    tbl[8]  = '{1, 1, 0, 1, 1, 8'h00, 17'h02A00};
    tbl[9]  = '{1, 1, 0, 1, 1, 8'h00, 17'h02A00};
    tbl[10] = '{1, 1, 0, 1, 1, 8'h00, 17'h02A00};
    tbl[11] = '{1, 1, 0, 1, 1, 8'h00, 17'h02A00};
    tbl[12] = '{1, 1, 1, 1, 1, 8'h00, 17'h02A00};
    tbl[13] = '{1, 1, 1, 1, 1, 8'h01, 17'h0E10C};
    tbl[14] = '{1, 1, 1, 1, 1, 8'h02, 17'h0E10E};
    tbl[15] = '{1, 1, 0, 1, 1, 8'h03, 17'h10003};

    set(0, 0, 0, 0, 0, '0, '0, 0, '0);
    @(negedge clk);

    // Table-driven: in-order stream and back-pressure saturation.
    for (int i = 0; i < 16; i++) begin
      set(tbl[i].rn, tbl[i].fen, tbl[i].rdy, 0, 0, '0, '0, 0, '0);
      #1;
      if (tbl[i].do_chk) begin
        chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].ev));
        if (tbl[i].ev) begin
          chk($sformatf("tbl%0d_pc", i), 32'(instr_pc), 32'(tbl[i].epc));
          chk($sformatf("tbl%0d_instr", i), 32'(instr), 32'(tbl[i].ein));
        end
      end
      tick();
    end

    // Store mid-stream takes the port; pc holds that cycle.
    set(0, 0, 0, 0, 0, '0, '0, 0, '0); #1; tick();
    for (int i = 0; i < 3; i++) begin set(1, 1, 1, 0, 0, '0, '0, 0, '0); #1; tick(); end
    set(1, 1, 1, 1, 1, 8'h20, 17'h00007, 0, '0);
    #1;
    chk("st_mem_ad", 32'(mem_ad), 32'h20);
    chk("st_mem_we", 32'(mem_we), 32'h1);
    chk("st_mem_data", 32'(mem_data), 32'h7);
    tick();
    for (int i = 0; i < 3; i++) begin set(1, 1, 1, 0, 0, '0, '0, 0, '0); #1; tick(); end
    set(1, 1, 1, 1, 0, 8'h20, '0, 0, '0);
    #1;
    chk("ld_rdata", 32'(ls_rdata), 32'h7);
    tick();

    // Redirect with a full queue.
    for (int i = 0; i < 3; i++) begin set(1, 1, 0, 0, 0, '0, '0, 0, '0); #1; tick(); end
    set(1, 1, 1, 0, 0, '0, '0, 1, 8'h0B); #1; tick();
    set(1, 1, 1, 0, 0, '0, '0, 0, '0); #1;
    chk("redir_valid_low", 32'(instr_valid), 32'h0);
    tick();
    set(1, 1, 1, 0, 0, '0, '0, 0, '0); #1;
    chk("redir_head_valid", 32'(instr_valid), 32'h1);
    chk("redir_head_pc", 32'(instr_pc), 32'h0B);
    tick();

    // pc wrap at the top of the address space.
    set(1, 1, 1, 0, 0, '0, '0, 1, 8'hFE); #1; tick();
    set(1, 1, 1, 0, 0, '0, '0, 0, '0); #1;
    chk("wrap_valid_low", 32'(instr_valid), 32'h0);
    tick();
    pcs[0] = 8'hFE; pcs[1] = 8'hFF; pcs[2] = 8'h00; pcs[3] = 8'h01;
    for (int i = 0; i < 4; i++) begin
      set(1, 1, 1, 0, 0, '0, '0, 0, '0); #1;
      chk($sformatf("wrap%0d_valid", i), 32'(instr_valid), 32'h1);
      chk($sformatf("wrap%0d_pc", i), 32'(instr_pc), 32'(pcs[i]));
      tick();
    end

    // Reset beats a simultaneous redirect.
    for (int i = 0; i < 3; i++) begin set(1, 1, 0, 0, 0, '0, '0, 0, '0); #1; tick(); end
    set(0, 1, 1, 0, 0, '0, '0, 1, 8'h55); #1; tick();
    set(1, 1, 1, 0, 0, '0, '0, 0, '0); #1;
    chk("rst_valid_low", 32'(instr_valid), 32'h0);
    tick();
    set(1, 1, 1, 0, 0, '0, '0, 0, '0); #1;
    chk("rst_resume_valid", 32'(instr_valid), 32'h1);
    chk("rst_resume_pc", 32'(instr_pc), 32'h0);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      bit rn, lq;
      rn = ($urandom_range(0, 63) != 0);
      lq = rn && ($urandom_range(0, 4) == 0);
      set(rn, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
          lq, $urandom_range(0, 1) == 1, AW'($urandom), W'($urandom),
          $urandom_range(0, 15) == 0, AW'($urandom));
      #1;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter W, default 17, meaning instruction/data word width.
REQ-002 SHALL have parameter AW, default 8, meaning memory address width (256 words).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port fetch_en  input  1  permits instruction fetch when high.
REQ-006 SHALL have port mem_ad  output  AW  address to the shared single-port memory.
REQ-007 SHALL have port mem_data  output  W  write data to memory (= ls_wdata).
REQ-008 SHALL have port mem_we  output  1  memory write enable.
REQ-009 SHALL have port mem_rd  input  W  memory read data, combinational from mem_ad, same cycle.
REQ-010 SHALL have port ls_req  input  1  load/store access request from execute stage.
REQ-011 SHALL have ports ls_we  input  1, ls_ad  input  AW, ls_wdata  input  W: store flag, address, store data.
REQ-012 SHALL have port ls_rdata  output  W  load data (= mem_rd, combinational).
REQ-013 SHALL have port redir_valid  input  1  branch/jump redirect strobe.
REQ-014 SHALL have port redir_pc  input  AW  redirect target.
REQ-015 SHALL have ports instr_valid  output  1, instr  output  W, instr_pc  output  AW: queue head to decode.
REQ-016 SHALL have port instr_ready  input  1  decode accepts head this cycle.

Function
REQ-017 SHALL hold program counter pc (AW bits) and a 2-entry FIFO of {pc, instruction} with occupancy count 0..2.
REQ-018 SHALL drive mem_ad = ls_req ? ls_ad : pc; mem_we = ls_req & ls_we; mem_data = ls_wdata, all combinational.
REQ-019 SHALL grant ls_req unconditionally in its cycle (load/store priority over fetch); no grant signal needed.
REQ-020 SHALL define pop = instr_valid & instr_ready.
REQ-021 SHALL define fetch = fetch_en & ~ls_req & ~redir_valid & (count<2 | pop).
REQ-022 On fetch, SHALL push {pc, mem_rd} into FIFO at the clock edge and set pc <= pc+1 modulo 2^AW (8'hFF wraps to 8'h00).
REQ-023 SHALL present queue head on instr/instr_pc with instr_valid = (count!=0); zero-latency bypass from memory to instr NOT provided (minimum 1-cycle fetch-to-valid).
REQ-024 SHALL support simultaneous push and pop, including at count==2, leaving count unchanged and order preserved.
REQ-025 SHALL keep instr/instr_pc stable while instr_valid & ~instr_ready.
REQ-026 On redir_valid, SHALL at that edge set count<=0, pc<=redir_pc, discard any pop/push; instr_valid is low the next cycle.
REQ-027 redir_valid with ls_req in same cycle: memory access SHALL proceed normally and redirect SHALL also take effect.
REQ-028 Stores SHALL NOT invalidate instructions already queued (no self-modifying-code coherence).
REQ-029 fetch_en low SHALL freeze pc and pushes; queued entries SHALL still drain via pop.

Reset
REQ-030 When rst_n is low at a rising edge, SHALL set pc=0, count=0, FIFO pointers=0; instr_valid=0 next cycle.
REQ-031 Reset SHALL override redirect, fetch and pop in the same cycle; FIFO data contents need not be cleared.
REQ-032 During reset, mem_we SHALL still follow ls_req & ls_we combinationally (upstream must hold ls_req low).

Verification
REQ-033 Reset, then fetch_en=1, instr_ready=1, mem[0..2]=17'h02A00,17'h0E10C,17'h0E10E -> instr_valid from cycle 1, instr_pc 0,1,2 with matching instr, one per cycle.
REQ-034 instr_ready=0 for 5 cycles after reset -> count saturates at 2, pc=2, instr_pc stays 0; release -> pcs 0,1,2,3 in order, no loss/duplicate.
REQ-035 ls_req=1, ls_we=1, ls_ad=8'h20, ls_wdata=17'h00007 for one cycle mid-stream -> mem_ad=8'h20, mem_we=1, pc does not advance that cycle, no bubble-induced duplicate.
REQ-036 redir_valid=1, redir_pc=8'h0B while count=2 -> next cycle instr_valid=0, following cycle instr_pc=8'h0B; old entries never appear.
REQ-037 redir_pc=8'hFE, run 4 fetches -> instr_pc sequence FE,FF,00,01.
REQ-038 rst_n=0 asserted mid-stream with count=2 and redir_valid=1 -> next cycle instr_valid=0, then fetch resumes at pc 0.
